// File: rtl/k005297_pkg.sv
// k005297_pkg: shared state encoding and constants for the K005297 page path.
package k005297_pkg;
  localparam int PG_BITS = 12;
  localparam int ROT_LOAD_STEP = 19;
  typedef enum logic [2:0] {IDLE, LOAD, ARM, VERIFY, SEEK, ERR} pg_state_e;
endpackage

// File: rtl/k005297_pgpos.sv
// k005297_pgpos: rotating page position counter with wrap and target compare.
module k005297_pgpos
  import k005297_pkg::*;
#(
  parameter int PAGE_COUNT = 2048
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic [PG_BITS-1:0] target_i,
  output logic [PG_BITS-1:0] count_o,
  output logic               match_o
);
  localparam logic [PG_BITS-1:0] LAST = PG_BITS'(PAGE_COUNT - 1);
  logic [PG_BITS-1:0] count_q, count_d;
  // match looks at the post-increment value so a hit lines up with the new position
  assign count_d = tick_i ? (count_q == LAST ? '0 : count_q + 1'b1) : count_q;
  assign match_o = count_d == target_i;
  assign count_o = count_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/k005297_pgctrl.sv
// k005297_pgctrl: page register load / shift verify / seek sequencer.
module k005297_pgctrl
  import k005297_pkg::*;
#(
  parameter int PAGE_COUNT  = 2048,
  parameter int VERIFY_TMO  = 4,
  parameter int SEEK_TMO_EN = 1
) (
  input  logic               i_MCLK,
  input  logic               i_SYS_RST_n,
  input  logic               i_CLK2M_PCEN_n,
  input  logic [19:0]        i_ROT20_n,
  input  logic               i_PG_REQ,
  input  logic [PG_BITS-1:0] i_PG_NUM,
  input  logic               i_PG_ABORT,
  input  logic               i_PGREG_SR_SHIFT,
  input  logic               i_PGREG_SR_LSB,
  output logic               o_PGREG_LD,
  output logic               o_PGREG_SR_LD_EN,
  output logic               o_PG_BUSY,
  output logic               o_PG_HIT,
  output logic               o_PG_ACK,
  output logic               o_PG_ERR,
  output logic [PG_BITS-1:0] o_PG_POS
);
  pg_state_e          state_q;
  logic [PG_BITS-1:0] target_q, cap_q, cap_d, scnt_q;
  logic [3:0]         bits_q;
  logic [7:0]         vcnt_q;
  logic               ld_q, ld_en_q, hit_q, ack_q, err_q;
  logic               en, tick, match, last_bit, vtmo, stmo, unused_rot;
  assign en         = ~i_CLK2M_PCEN_n;
  assign tick       = en & ~i_ROT20_n[ROT_LOAD_STEP];
  assign unused_rot = ^i_ROT20_n[ROT_LOAD_STEP-1:0];
  assign cap_d      = {i_PGREG_SR_LSB, cap_q[PG_BITS-1:1]};
  assign last_bit   = i_PGREG_SR_SHIFT && bits_q == 4'(PG_BITS - 1);
  assign vtmo       = tick && vcnt_q == 8'(VERIFY_TMO - 1);
  assign stmo       = (SEEK_TMO_EN != 0) && tick && scnt_q == PG_BITS'(PAGE_COUNT - 1);
  k005297_pgpos #(.PAGE_COUNT(PAGE_COUNT)) u_pgpos (
    .clk_i   (i_MCLK),
    .rst_ni  (i_SYS_RST_n),
    .tick_i  (tick),
    .target_i(target_q),
    .count_o (o_PG_POS),
    .match_o (match)
  );
  // a request arriving while ACK is still presented belongs to the finished operation and is dropped
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n)
    if (!i_SYS_RST_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      cap_q    <= '0;
      scnt_q   <= '0;
      bits_q   <= '0;
      vcnt_q   <= '0;
      ld_q     <= 1'b0;
      ld_en_q  <= 1'b0;
      hit_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (en) begin
      ld_q    <= 1'b0;
      ld_en_q <= 1'b0;
      hit_q   <= 1'b0;
      ack_q   <= 1'b0;
      if (i_PG_ABORT && state_q != IDLE) state_q <= IDLE;
      else
        case (state_q)
          IDLE:
            if (i_PG_REQ && !ack_q) begin
              target_q <= i_PG_NUM;
              err_q    <= 1'b0;
              ld_q     <= 1'b1;
              state_q  <= LOAD;
            end
          LOAD: begin
            ld_en_q <= 1'b1;
            state_q <= ARM;
          end
          ARM:
            if (tick) begin
              cap_q   <= '0;
              bits_q  <= '0;
              vcnt_q  <= '0;
              state_q <= VERIFY;
            end else ld_en_q <= 1'b1;
          VERIFY: begin
            if (i_PGREG_SR_SHIFT) begin
              cap_q  <= cap_d;
              bits_q <= bits_q + 4'd1;
            end
            if (tick) vcnt_q <= vcnt_q + 8'd1;
            if (last_bit) begin
              scnt_q  <= '0;
              state_q <= cap_d == target_q ? SEEK : ERR;
            end else if (vtmo) state_q <= ERR;
          end
          SEEK:
            if (match) begin
              hit_q   <= 1'b1;
              ack_q   <= 1'b1;
              state_q <= IDLE;
            end else if (stmo) state_q <= ERR;
            else if (tick) scnt_q <= scnt_q + 1'b1;
          ERR: begin
            err_q   <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
    end
  assign o_PGREG_LD       = ld_q;
  assign o_PGREG_SR_LD_EN = ld_en_q;
  assign o_PG_BUSY        = state_q != IDLE;
  assign o_PG_HIT         = hit_q;
  assign o_PG_ACK         = ack_q;
  assign o_PG_ERR         = err_q;
endmodule

// File: tb/tb_k005297_pgctrl.sv
// tb_k005297_pgctrl: directed stimulus with an ACK-driven scoreboard.
module tb_k005297_pgctrl;
  localparam int PC = 2048;
  typedef struct packed {logic hit; logic err; logic [11:0] pos;} exp_t;
  logic        clk = 0, rst_n = 0, pcen_n = 1, req = 0, abort = 0, shift = 0, lsb = 0;
  logic [19:0] rot20 = '1;
  logic [11:0] num = '0, pos, exp_pos = '0;
  logic        ld, ld_en, busy, hit, ack, err, prev_ack = 0;
  exp_t        q[$];
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;
  k005297_pgctrl #(.PAGE_COUNT(PC), .VERIFY_TMO(4), .SEEK_TMO_EN(1)) dut (
    .i_MCLK          (clk),
    .i_SYS_RST_n     (rst_n),
    .i_CLK2M_PCEN_n  (pcen_n),
    .i_ROT20_n       (rot20),
    .i_PG_REQ        (req),
    .i_PG_NUM        (num),
    .i_PG_ABORT      (abort),
    .i_PGREG_SR_SHIFT(shift),
    .i_PGREG_SR_LSB  (lsb),
    .o_PGREG_LD      (ld),
    .o_PGREG_SR_LD_EN(ld_en),
    .o_PG_BUSY       (busy),
    .o_PG_HIT        (hit),
    .o_PG_ACK        (ack),
    .o_PG_ERR        (err),
    .o_PG_POS        (pos)
  );
  function automatic logic [11:0] padd(input logic [11:0] p, input int n);
    int v;
    v = (int'(p) + n) % PC;
    return 12'(v);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask
  task automatic cyc(input bit rot, input bit en = 1'b1);
    rot20  = rot ? ~20'h80000 : ~20'h1;
    pcen_n = !en;
    @(posedge clk);
    if (rot && en) exp_pos = padd(exp_pos, 1);
    #1;
    req   = 0;
    abort = 0;
    shift = 0;
  endtask
  task automatic start(input logic [11:0] t);
    req = 1;
    num = t;
    cyc(0);
    chk("ld_pulse", 32'(ld), 1);
    chk("busy_load", 32'(busy), 1);
    chk("err_clr", 32'(err), 0);
    cyc(0);
    chk("ld_once", 32'(ld), 0);
    chk("ld_en_arm", 32'(ld_en), 1);
    cyc(0);
    chk("ld_en_hold", 32'(ld_en), 1);
    cyc(1);
    chk("ld_en_drop", 32'(ld_en), 0);
    chk("busy_verify", 32'(busy), 1);
  endtask
  task automatic shift12(input logic [11:0] v);
    for (int i = 0; i < 12; i++) begin
      shift = 1;
      lsb   = v[i];
      cyc(0);
    end
  endtask
  task automatic finish(input bit h, input bit e, input int off, input logic [11:0] t, input bit req_ack = 1'b0);
    exp_t x;
    int n = 0;
    x.hit = h;
    x.err = e;
    x.pos = h ? t : padd(exp_pos, off);
    q.push_back(x);
    while (busy && n < 5000) begin
      cyc(1);
      n++;
    end
    chk("done_in_budget", 32'(busy), 0);
    if (req_ack) begin
      req = 1;
      num = 12'h3C3;
    end
    cyc(0);
    if (req_ack) begin
      chk("req_in_ack_ignored", 32'(busy), 0);
      chk("err_kept", 32'(err), 32'(e));
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && ack && !prev_ack) begin
      if (q.size() == 0) chk("unexpected_ack", 32'(q.size()), 1);
      else begin : pop
        exp_t e;
        e = q.pop_front();
        chk("ack_hit", 32'(hit), 32'(e.hit));
        chk("ack_err", 32'(err), 32'(e.err));
        chk("ack_pos", 32'(pos), 32'(e.pos));
      end
    end
    if (rst_n && hit) chk("hit_with_ack", 32'(ack), 32'(hit));
    prev_ack = ack;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic [11:0] t;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cyc(1, i[0]);
    chk("reset_outs", 32'({ld, ld_en, busy, hit, ack, err, pos}), 0);
    rst_n   = 1;
    exp_pos = '0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1'b1);
      cyc(1, 1'b0);
    end
    chk("pos_after_10", 32'(pos), 10);
    chk("idle_not_busy", 32'(busy), 0);
    while (exp_pos != 12'h002) cyc(1);
    start(12'h005);
    shift12(12'h005);
    finish(1, 0, 0, 12'h005);
    while (exp_pos != 12'h7FD) cyc(1);
    start(12'h7FF);
    shift12(12'h7FF);
    finish(1, 0, 0, 12'h7FF);
    while (exp_pos != 12'h7FE) cyc(1);
    start(12'h000);
    shift12(12'h000);
    finish(1, 0, 0, 12'h000);
    start(12'h0A4);
    shift12(12'h0A5);
    finish(0, 1, 1, 12'h0A4, 1'b1);
    start(12'h123);
    finish(0, 1, 5, 12'h123);
    start(12'hFFF);
    shift12(12'hFFF);
    finish(0, 1, 1, 12'hFFF);
    req = 1;
    num = 12'h010;
    cyc(0);
    cyc(0);
    chk("arm_ld_en", 32'(ld_en), 1);
    abort = 1;
    cyc(0);
    chk("abort_arm_busy", 32'(busy), 0);
    chk("abort_arm_ld_en", 32'(ld_en), 0);
    chk("abort_arm_ack", 32'(ack), 0);
    cyc(0);
    t = padd(exp_pos, 50);
    start(t);
    shift12(t);
    repeat (3) cyc(1);
    req = 1;
    num = padd(exp_pos, 2);
    cyc(1);
    chk("seek_req_busy", 32'(busy), 1);
    chk("seek_req_no_ld", 32'(ld), 0);
    finish(1, 0, 0, t);
    t = padd(exp_pos, 500);
    start(t);
    shift12(t);
    cyc(1);
    cyc(1);
    abort = 1;
    cyc(1);
    chk("abort_seek_busy", 32'(busy), 0);
    chk("abort_seek_ack", 32'(ack), 0);
    chk("abort_seek_err", 32'(err), 0);
    cyc(0);
    cyc(0);
    start(12'h0F0);
    for (int i = 0; i < 5; i++) begin
      shift = 1;
      lsb   = 1'b0;
      cyc(0);
    end
    #2 rst_n = 0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_pos", 32'(pos), 0);
    exp_pos = '0;
    @(posedge clk);
    #1 rst_n = 1;
    cyc(0);
    chk("post_rst_idle", 32'({busy, ld, ld_en, err}), 0);
    chk("pending_acks", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
